dac_sample_scheduler: RTL and testbench

Paces audio samples from the CPU to the PWM DAC at a fixed sample rate. It buffers CPU-written samples in a small FIFO. It then releases exactly one code every SAMPLE_PERIOD cycles to the DAC input. Underflow is handled deterministically by holding the last code, and is counted for software. It sits between the CPU memory-mapped audio registers and the DAC, in the cpu_clk domain.

---
 rtl/dac_sample_scheduler.sv | 152 +++++++++++++++
 tb/tb_dac_sample_scheduler.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_sample_scheduler.sv
// dac_sample_scheduler: buffers CPU audio samples and releases one code per sample period.
// On FIFO underflow the last code is held and the event is counted.
module dac_sample_scheduler #(
   parameter int CODE_WIDTH    = 10,
   parameter int FIFO_DEPTH    = 8,
   parameter int SAMPLE_PERIOD = 1927,
   parameter int PRIME_LEVEL   = 4
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic                          flush,
   input  logic                          in_valid,
   input  logic [CODE_WIDTH-1:0]         in_data,
   output logic                          in_ready,
   output logic [CODE_WIDTH-1:0]         dac_code,
   output logic                          dac_load,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          running,
   output logic                          underflow,
   output logic [15:0]                   underflow_cnt,
   input  logic                          clr_underflow
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(SAMPLE_PERIOD);

   localparam logic [CODE_WIDTH-1:0] MIDSCALE  = {1'b1, {(CODE_WIDTH-1){1'b0}}};
   localparam logic [TW-1:0]         TICK_LAST = TW'(SAMPLE_PERIOD - 1);
   localparam logic [PW:0]           DEPTH_C   = (PW+1)'(FIFO_DEPTH);
   localparam logic [PW:0]           PRIME_C   = (PW+1)'(PRIME_LEVEL);

   typedef enum logic [1:0] {
      IDLE,
      PRIME,
      RUN
   } state_t;

   state_t                state_q, state_d;
   logic [TW-1:0]         tick_q, tick_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [PW:0]           count_q, count_d;
   logic [CODE_WIDTH-1:0] code_q, code_d;
   logic                  load_q, load_d;
   logic                  uf_q, uf_d;
   logic [15:0]           ucnt_q, ucnt_d;
   logic [CODE_WIDTH-1:0] mem_q [FIFO_DEPTH];

   logic boundary;
   logic push;
   logic pop;

   always_comb begin
      in_ready = (count_q != DEPTH_C);
      boundary = (state_q == RUN) && (tick_q == TICK_LAST);
      push     = in_valid && in_ready && !flush;
      pop      = boundary && (count_q != '0) && !flush;
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
      end
   end

   // A boundary always completes its load before an enable drop is honoured.
   always_comb begin
      state_d = state_q;
      tick_d  = '0;
      code_d  = code_q;
      load_d  = boundary;
      unique case (state_q)
         IDLE: begin
            code_d = MIDSCALE;
            if (enable) state_d = PRIME;
         end
         PRIME: begin
            if (!enable) state_d = IDLE;
            else if (count_q >= PRIME_C) state_d = RUN;
         end
         RUN: begin
            if (boundary) begin
               if (pop) code_d = mem_q[rd_ptr_q];
            end else if (!enable) begin
               state_d = IDLE;
               code_d  = MIDSCALE;
            end else begin
               tick_d = tick_q + TW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      uf_d   = uf_q;
      ucnt_d = ucnt_q;
      if (clr_underflow) begin
         uf_d   = 1'b0;
         ucnt_d = '0;
      end else if (boundary && (count_q == '0)) begin
         uf_d = 1'b1;
         if (ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         tick_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         code_q   <= MIDSCALE;
         load_q   <= 1'b0;
         uf_q     <= 1'b0;
         ucnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         tick_q   <= tick_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         code_q   <= code_d;
         load_q   <= load_d;
         uf_q     <= uf_d;
         ucnt_q   <= ucnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_data;
   end

   assign dac_code      = code_q;
   assign dac_load      = load_q;
   assign fifo_count    = count_q;
   assign running       = (state_q == RUN);
   assign underflow     = uf_q;
   assign underflow_cnt = ucnt_q;

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// tb_dac_sample_scheduler: directed plus randomized checks of the sample scheduler
// against a queue-based behavioural model.
module tb_dac_sample_scheduler;

   localparam int CW  = 10;
   localparam int DEP = 8;
   localparam int P   = 4;
   localparam int PL  = 4;
   localparam logic [CW-1:0] MID = 10'd512;

   localparam int M_IDLE  = 0;
   localparam int M_PRIME = 1;
   localparam int M_RUN   = 2;

   logic          clk;
   logic          rst_n;
   logic          enable;
   logic          flush;
   logic          in_valid;
   logic [CW-1:0] in_data;
   logic          in_ready;
   logic [CW-1:0] dac_code;
   logic          dac_load;
   logic [3:0]    fifo_count;
   logic          running;
   logic          underflow;
   logic [15:0]   underflow_cnt;
   logic          clr_underflow;

   int n_vec;
   int n_miss;
   bit chk_en;

   dac_sample_scheduler #(
      .CODE_WIDTH(CW),
      .FIFO_DEPTH(DEP),
      .SAMPLE_PERIOD(P),
      .PRIME_LEVEL(PL)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .enable(enable),
      .flush(flush),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_ready(in_ready),
      .dac_code(dac_code),
      .dac_load(dac_load),
      .fifo_count(fifo_count),
      .running(running),
      .underflow(underflow),
      .underflow_cnt(underflow_cnt),
      .clr_underflow(clr_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: sample queue, playback mode and cycles spent playing.
   logic [CW-1:0] mq[$];
   int            m_mode;
   int            m_age;
   logic [CW-1:0] m_code;
   bit            m_load;
   bit            m_uf;
   int            m_ucnt;

   always @(posedge clk or negedge rst_n) begin : model
      int cnt;
      bit bnd;
      bit pp;
      bit ps;
      if (!rst_n) begin
         mq.delete();
         m_mode = M_IDLE;
         m_age  = 0;
         m_code = MID;
         m_load = 0;
         m_uf   = 0;
         m_ucnt = 0;
      end else begin
         cnt = mq.size();
         bnd = (m_mode == M_RUN) && ((m_age % P) == P - 1);
         ps  = in_valid && (cnt != DEP) && !flush;
         pp  = bnd && (cnt > 0) && !flush;
         m_load = bnd;
         if (clr_underflow) begin
            m_uf   = 0;
            m_ucnt = 0;
         end else if (bnd && cnt == 0) begin
            m_uf = 1;
            if (m_ucnt < 65535) m_ucnt++;
         end
         if (pp) m_code = mq[0];
         case (m_mode)
            M_IDLE: if (enable) m_mode = M_PRIME;
            M_PRIME: begin
               if (!enable) m_mode = M_IDLE;
               else if (cnt >= PL) begin
                  m_mode = M_RUN;
                  m_age  = 0;
               end
            end
            default: begin
               if (!bnd && !enable) begin
                  m_mode = M_IDLE;
                  m_code = MID;
               end else m_age++;
            end
         endcase
         if (flush) mq.delete();
         else begin
            if (pp) void'(mq.pop_front());
            if (ps) mq.push_back(in_data);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && chk_en) begin
         chk("in_ready", in_ready, mq.size() != DEP);
         chk("fifo_count", fifo_count, mq.size());
         chk("dac_code", dac_code, m_code);
         chk("dac_load", dac_load, m_load);
         chk("running", running, m_mode == M_RUN);
         chk("underflow", underflow, m_uf);
         chk("underflow_cnt", underflow_cnt, m_ucnt);
      end
   end

   task automatic wait_load(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!dac_load && n < 50);
      chk("load_seen", dac_load, 1);
   endtask

   logic [CW-1:0] pushed [6];
   int            loads;
   int            n;

   initial begin
      n_vec = 0;
      n_miss = 0;
      chk_en = 0;
      rst_n = 0;
      enable = 0;
      flush = 0;
      in_valid = 0;
      in_data = '0;
      clr_underflow = 0;
      repeat (3) @(negedge clk);
      rst_n = 1;
      chk_en = 1;
      @(negedge clk);
      chk("rst_code", dac_code, 512);
      chk("rst_ready", in_ready, 1);
      chk("rst_count", fifo_count, 0);
      chk("rst_running", running, 0);

      // Enabled with an empty FIFO: priming never completes.
      enable = 1;
      loads = 0;
      repeat (100) begin
         @(negedge clk);
         if (dac_load) loads++;
      end
      chk("prime_no_load", loads, 0);
      chk("prime_not_running", running, 0);
      enable = 0;
      @(negedge clk);

      for (int i = 0; i < 4; i++) begin
         in_valid = 1;
         in_data = CW'(16 * (i + 1));
         @(negedge clk);
      end
      in_valid = 0;
      enable = 1;
      wait_load(n);
      chk("first_load_lat", n, P + 2);
      chk("code_0", dac_code, 10'h010);
      for (int i = 1; i < 4; i++) begin
         wait_load(n);
         chk("load_gap", n, P);
         chk("code_n", dac_code, CW'(16 * (i + 1)));
      end
      chk("drained", fifo_count, 0);

      for (int i = 0; i < 2; i++) begin
         wait_load(n);
         chk("uf_gap", n, P);
         chk("uf_hold", dac_code, 10'h040);
      end
      chk("uf_flag", underflow, 1);
      chk("uf_cnt", underflow_cnt, 2);
      clr_underflow = 1;
      @(negedge clk);
      clr_underflow = 0;
      chk("clr_flag", underflow, 0);
      chk("clr_cnt", underflow_cnt, 0);
      enable = 0;
      @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         in_valid = 1;
         in_data = CW'($urandom);
         @(negedge clk);
         if (i == 7) begin
            chk("full_ready", in_ready, 0);
            chk("full_count", fifo_count, 8);
         end
      end
      in_valid = 0;
      chk("drop_9th", fifo_count, 8);
      in_valid = 1;
      in_data = 10'h155;
      flush = 1;
      @(negedge clk);
      flush = 0;
      @(negedge clk);
      chk("one_after_flush", fifo_count, 1);
      flush = 1;
      @(negedge clk);
      flush = 0;
      in_valid = 0;
      chk("flush_push", fifo_count, 0);
      chk("flush_ready", in_ready, 1);

      for (int i = 0; i < 6; i++) begin
         pushed[i] = CW'($urandom);
         in_valid = 1;
         in_data = pushed[i];
         @(negedge clk);
      end
      in_valid = 0;
      enable = 1;
      wait_load(n);
      chk("run_code_a", dac_code, pushed[0]);
      chk("run_count", fifo_count, 5);
      enable = 0;
      @(negedge clk);
      chk("stop_running", running, 0);
      chk("stop_code", dac_code, 512);
      chk("stop_count", fifo_count, 5);
      enable = 1;
      wait_load(n);
      chk("reenable_lat", n, P + 2);
      chk("run_code_b", dac_code, pushed[1]);

      repeat (2) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 0;
      #1;
      chk("arst_code", dac_code, 512);
      chk("arst_load", dac_load, 0);
      chk("arst_running", running, 0);
      chk("arst_count", fifo_count, 0);
      chk("arst_ready", in_ready, 1);
      chk("arst_uf", underflow_cnt, 0);
      enable = 0;
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);

      enable = 1;
      for (int c = 0; c < 3000; c++) begin
         in_valid = ($urandom_range(99) < (c < 1500 ? 35 : 20));
         in_data = CW'($urandom);
         flush = ($urandom_range(199) == 0);
         clr_underflow = ($urandom_range(99) < 2);
         if ($urandom_range(99) < 3) enable = ~enable;
         @(negedge clk);
      end
      in_valid = 0;
      flush = 0;
      clr_underflow = 0;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
